// File: rtl/sign_narrower_pkg.sv
// rtl/sign_narrower_pkg.sv - shared widths, mode encodings and saturation constants for sign_narrower
package sign_narrower_pkg;

    localparam int IN_W_DEF  = 32;
    localparam int OUT_W_DEF = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 16;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    localparam logic [15:0] S16_MAX = 16'h7FFF;
    localparam logic [15:0] S16_MIN = 16'h8000;
    localparam logic [15:0] U16_MAX = 16'hFFFF;

endpackage

// File: rtl/sign_narrower_narrow_check.sv
// rtl/sign_narrower_narrow_check.sv - combinational narrowing and fit detection; SIGN_NARROWER_SAT_EN selects saturation of lossy values
module narrow_check
    import sign_narrower_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic [OUT_W-1:0] out_data,
    output logic             out_fit
);

`ifdef SIGN_NARROWER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic fit_s;
    logic fit_u;

    always_comb begin
        // Signed fit needs the dropped bits plus the new sign bit to be a pure sign extension.
        fit_s = (in_data[IN_W-1:OUT_W-1] == '0) || (in_data[IN_W-1:OUT_W-1] == '1);
        fit_u = (in_data[IN_W-1:OUT_W] == '0);

        if (in_signed == MODE_UNSIGNED) begin
            out_fit = fit_u;
        end else begin
            out_fit = fit_s;
        end

        out_data = in_data[OUT_W-1:0];
        if (SAT_EN && !out_fit) begin
            if (in_signed == MODE_SIGNED) begin
                out_data = in_data[IN_W-1] ? OUT_W'(S16_MIN) : OUT_W'(S16_MAX);
            end else begin
                out_data = OUT_W'(U16_MAX);
            end
        end
    end

endmodule

// File: rtl/sign_narrower.sv
// rtl/sign_narrower.sv - 32->16 narrowing stage with output FIFO and saturating lossy-value counter (SIGN_NARROWER_SAT_EN via narrow_check)
module sign_narrower
    import sign_narrower_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_fit,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [OUT_W-1:0] data_mem_q [DEPTH];
    logic [OUT_W-1:0] data_mem_d [DEPTH];
    logic [DEPTH-1:0] fit_mem_q, fit_mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;

    logic [OUT_W-1:0] nar_data;
    logic             nar_fit;
    logic             push;
    logic             pop;

    narrow_check #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_check (
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_data  (nar_data),
        .out_fit   (nar_fit)
    );

    always_comb begin
        // Full blocks input even when a pop happens this cycle: no pass-through on full.
        in_ready  = (occ_q != OCC_FULL);
        out_valid = (occ_q != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;

        data_mem_d = data_mem_q;
        fit_mem_d  = fit_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        ovf_d      = ovf_q;

        if (push) begin
            data_mem_d[wr_ptr_q] = nar_data;
            fit_mem_d[wr_ptr_q]  = nar_fit;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!push && pop) begin
            occ_d = occ_q - OCC_W'(1);
        end

        if (clr_count) begin
            ovf_d = '0;
        end else if (push && !nar_fit && (ovf_q != '1)) begin
            ovf_d = ovf_q + CNT_W'(1);
        end

        out_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
        out_fit   = out_valid && fit_mem_q[rd_ptr_q];
        ovf_count = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem_q[i] <= '0;
            end
            fit_mem_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            ovf_q     <= '0;
        end else begin
            data_mem_q <= data_mem_d;
            fit_mem_q  <= fit_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sign_narrower.sv
// tb/tb_sign_narrower.sv - directed bench with queue model for sign_narrower (honours SIGN_NARROWER_SAT_EN)
module tb_sign_narrower;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef SIGN_NARROWER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_signed;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_fit;
    logic [CNT_W-1:0] ovf_count;
    logic        clr_count;

    int n_chk  = 0;
    int n_fail = 0;

    sign_narrower #(
        .IN_W  (32),
        .OUT_W (16),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_fit   (out_fit),
        .ovf_count (ovf_count),
        .clr_count (clr_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_fit(input logic [31:0] d, input bit s);
        if (s) return ($signed(d) >= -32768) && ($signed(d) <= 32767);
        return d <= 32'd65535;
    endfunction

    function automatic logic [15:0] m_data(input logic [31:0] d, input bit s);
        if (m_fit(d, s) || !SAT) return d[15:0];
        if (!s) return 16'hFFFF;
        return ($signed(d) < 0) ? 16'h8000 : 16'h7FFF;
    endfunction

    logic [16:0] mq[$];
    int          m_cnt  = 0;
    bit          chk_en = 1'b0;
    logic [16:0] m_head;
    bit          m_push, m_pop, m_f;

    // Outputs are compared on the falling edge, then the model absorbs what the next rising edge will do.
    always @(negedge clk) begin
        if (chk_en) begin
            m_head = (mq.size() != 0) ? mq[0] : 17'h0;
            chk("out_valid", out_valid, mq.size() != 0);
            chk("in_ready", in_ready, mq.size() < DEPTH);
            chk("out_data", out_data, m_head[15:0]);
            chk("out_fit", out_fit, m_head[16]);
            chk("ovf_count", ovf_count, m_cnt);
        end
        if (reset) begin
            mq.delete();
            m_cnt  = 0;
            chk_en = 1'b1;
        end else begin
            m_push = in_valid && (mq.size() < DEPTH);
            m_pop  = (mq.size() != 0) && out_ready;
            m_f    = m_fit(in_data, in_signed);
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({m_f, m_data(in_data, in_signed)});
            if (clr_count) m_cnt = 0;
            else if (m_push && !m_f && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    task automatic set_in(input bit v, input logic [31:0] d, input bit s, input bit r);
        in_valid  = v;
        in_data   = d;
        in_signed = s;
        out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; clr_count = 1'b0;
        set_in(0, 32'h0, 0, 0);
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovf", ovf_count, 0);
        chk("model_fit_s_lo", m_fit(32'hFFFF_8000, 1), 1);
        chk("model_fit_s_hi", m_fit(32'h0000_8000, 1), 0);
        chk("model_fit_u", m_fit(32'h0000_FFFF, 0), 1);
        tick();

        // Signed minimum fits exactly
        set_in(1, 32'hFFFF_8000, 1, 1); tick();
        set_in(0, 32'h0, 0, 1);
        @(negedge clk);
        chk("t1_data", out_data, 16'h8000);
        chk("t1_fit", out_fit, 1);
        chk("t1_ovf", ovf_count, 0);
        tick();

        // Signed overflow positive
        set_in(1, 32'h0001_2345, 1, 1); tick();
        set_in(0, 32'h0, 0, 1);
        @(negedge clk);
        chk("t2_data", out_data, SAT ? 16'h7FFF : 16'h2345);
        chk("t2_fit", out_fit, 0);
        chk("t2_ovf", ovf_count, 1);
        tick();

        // Same value unsigned then signed
        set_in(1, 32'h0000_FFFF, 0, 0); tick();
        set_in(1, 32'h0000_FFFF, 1, 0); tick();
        set_in(0, 32'h0, 0, 0);
        @(negedge clk);
        chk("t3a_data", out_data, 16'hFFFF);
        chk("t3a_fit", out_fit, 1);
        tick();
        set_in(0, 32'h0, 0, 1); tick();
        set_in(0, 32'h0, 0, 0);
        @(negedge clk);
        chk("t3b_data", out_data, SAT ? 16'h7FFF : 16'hFFFF);
        chk("t3b_fit", out_fit, 0);
        chk("t3b_ovf", ovf_count, 2);
        tick();
        set_in(0, 32'h0, 0, 1); tick();

        // Fill to full with consumer stalled, fifth word held
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'h0000_0100 + 32'(i), 1, 0); tick();
        end
        set_in(1, 32'hFFFF_0104, 1, 0);
        @(negedge clk);
        chk("t4_full_ready", in_ready, 0);
        tick(); tick();
        @(negedge clk);
        chk("t4_held_ready", in_ready, 0);
        chk("t4_held_head", out_data, 16'h0100);
        tick();
        set_in(1, 32'hFFFF_0104, 1, 1); tick();
        @(negedge clk);
        chk("t4_ready_after_pop", in_ready, 1);
        tick();
        set_in(0, 32'h0, 0, 1);
        for (int i = 0; i < 5; i++) tick();
        @(negedge clk);
        chk("t4_drained", out_valid, 0);
        tick();

        // Steady state at occupancy 2
        set_in(1, 32'h0000_0A00, 0, 0); tick();
        set_in(1, 32'h0000_0A01, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 32'h0000_0B00 + 32'(i), 0, 1); tick();
        end
        set_in(1, 32'h0000_0C00, 0, 0);
        @(negedge clk);
        chk("t5_head", out_data, 16'h0B08);
        chk("t5_valid", out_valid, 1);
        tick();
        reset = 1'b1; tick();
        reset = 1'b0;
        set_in(0, 32'h0, 0, 0);
        @(negedge clk);
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ovf", ovf_count, 0);
        chk("t5_rst_ready", in_ready, 1);
        tick();

        // Counter saturation then clear beating a lossy push
        for (int i = 0; i < 18; i++) begin
            set_in(1, 32'h8000_0000, 1, 1); tick();
        end
        set_in(0, 32'h0, 0, 1);
        @(negedge clk);
        chk("t6_sat", ovf_count, 4'hF);
        tick();
        set_in(1, 32'h1234_5678, 0, 1);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        set_in(0, 32'h0, 0, 0);
        @(negedge clk);
        chk("t6_clr", ovf_count, 0);
        chk("t6_clr_data", out_data, SAT ? 16'hFFFF : 16'h5678);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sign_narrower.md
# sign_narrower

Inverse of the datapath sign extender: accepts 32-bit register values over a valid/ready handshake, narrows each to a 16-bit half-word, and flags whether the value fit without loss. Sits between the register-file read port and the half-word store / immediate-encode paths. A small output FIFO decouples producer and consumer, and a saturating counter tracks lossy narrowings.

## Interface
- IN_W, 32, input data width
- OUT_W, 16, output data width
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- CNT_W, 16, width of overflow counter
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  producer has a value
- in_ready  out  1  block can accept; = !full
- in_data  in  IN_W  value to narrow
- in_signed  in  1  1: signed narrowing; 0: unsigned narrowing
- out_valid  out  1  FIFO head valid; = !empty
- out_ready  in  1  consumer takes head
- out_data  out  OUT_W  narrowed value at FIFO head; 0 when empty
- out_fit  out  1  head value was representable exactly; 0 when empty
- ovf_count  out  CNT_W  number of accepted non-fitting values, saturating
- clr_count  in  1  synchronous clear of ovf_count

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- Fit rule, signed: in_data[31:15] all equal. Unsigned: in_data[31:16] all zero.
- Stored data when fit: in_data[15:0]. When not fit: in_data[15:0] (truncation) unless saturation compiled in (see Configuration).
- Stored out_fit = fit result; computed on the pushed word, in_signed sampled with it.
- ovf_count increments by 1 on each push with fit=0; holds at all-ones; clr_count takes priority over increment (clears to 0 in same cycle).
- Simultaneous push and pop with 0 < occupancy < DEPTH: occupancy unchanged, both happen.
- Full: in_ready=0 even if a pop occurs that cycle (no pass-through-on-full).
- Empty: out_valid=0; push-and-pop same cycle impossible since out_valid=0; no bypass.
- Read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH distinguishes full/empty.
- Inputs while in_valid=0 are ignored; in_data may change freely while stalled.

## Timing
- Reset: pointers=0, occupancy=0, ovf_count=0, out_valid=0, out_data=0, out_fit=0, in_ready=1.
- Reset mid-operation discards all FIFO contents; in_ready=1 the cycle after reset deasserts.
- Latency: word pushed at edge N appears at head with out_valid=1 after edge N (visible in cycle N+1) when FIFO was empty.
- Throughput: one word per cycle while not full and consumer ready.
- ovf_count reflects a push at edge N from cycle N+1.
- out_data/out_fit held stable while out_valid=1 and out_ready=0.

## Configuration
- SIGN_NARROWER_SAT_EN defined: non-fitting values stored saturated — signed: 16'h7FFF if in_data[31]=0, 16'h8000 if 1; unsigned: 16'hFFFF. out_fit still 0.
- Undefined: non-fitting values truncated to in_data[15:0]. Fit detection and counter unaffected.

## Structure
- Package sign_narrower_pkg: IN_W/OUT_W/CNT_W defaults, signed/unsigned mode constants, saturation constants (S16_MAX, S16_MIN, U16_MAX).
- Sub-module narrow_check: combinational in_data + in_signed -> narrowed data + fit; holds the macro-controlled saturation logic. Top holds FIFO, pointers, occupancy, counter.

## Test plan
- Reset, then push 32'hFFFF_8000 signed, out_ready=1 -> next cycle out_data=16'h8000, out_fit=1, ovf_count=0.
- Push 32'h0001_2345 signed -> out_fit=0, out_data=16'h2345 (macro off) / 16'h7FFF (macro on), ovf_count=1.
- Push 32'h0000_FFFF unsigned then signed -> first out_fit=1 data 16'hFFFF; second out_fit=0.
- out_ready=0, push 5 words into DEPTH=4 -> in_ready=0 after 4th; 5th held; drain yields 4 words in order, then 5th accepted.
- Steady push+pop every cycle at occupancy 2 for 10 cycles -> occupancy stays 2, order preserved; assert reset mid-stream -> out_valid=0, ovf_count=0 next cycle.
- Force ovf_count near all-ones with CNT_W=4, push 3 non-fitting -> holds 4'hF; clr_count with simultaneous non-fitting push -> 0.
